bridge_cmd_ctrl: RTL and testbench
==================================

// Module: bridge_cmd_ctrl
// PURPOSE
//  Parametrised successor of the bus-strobed bridge command controller.
//  - Decodes 2-word frames on a filtered strobe/bus pair.
//  - Runs the charge/start timing sequence and drives the 4-leg H-bridge pattern.
//  - New behaviour: dead-time insertion between non-zero patterns, and a clearable error latch.
//  - Sits between the input filter bank and the bridge gate-drive pins.
// PARAMETERS
//  FREQ          50000000  clk frequency, Hz
//  BUS_W         3         command bus width, >=3; opcodes use bits [2:0], upper bits must be 0
//  START_WAIT_S  15        seconds from START to o_st rising
//  CH_HOLD_S     1         seconds o_ch stays high after o_st rises
//  DEADTIME_CYC  50        all-legs-off cycles between two different non-zero patterns, >=1
//  N_ERR         8         number of filtered, active-high fault inputs
// PORTS
//  clk         in   1      system clock
//  rstn        in   1      synchronous reset, active-low
//  strb        in   1      filtered bus strobe; a word is taken on its 1->0 edge
//  bus         in   BUS_W  filtered command word
//  err         in   N_ERR  fault inputs, active-high, level
//  stop_k      in   1      emergency stop, active-high; also counts as a fault
//  err_clr     in   1      one-cycle pulse requesting error-latch clear
//  o_top       out  4      high-side leg gates [3:0] = TOP1..TOP4
//  o_bot       out  4      low-side leg gates [3:0] = BOT1..BOT4
//  o_plus, o_minus, o_pause_p, o_pause_n   out 1 each   applied-pattern flags
//  o_st, o_ch, o_fan, o_break, o_stop      out 1 each   start/charge/fan/fault/stop latches
//  idle        out  1      frame decoder in IDLE
//  err_active  out  1      error latch set
// BEHAVIOUR
//  Reset (rstn=0 at posedge clk)
//  - All outputs 0 except idle=1.
//  - Strobe history register = 0, so a strobe held low through reset produces no edge.
//  - Timers = 0. Reset mid-frame, mid-start or mid-dead-time aborts everything.
//  Frame decode
//  - FSM: IDLE -> ARG on an opcode word, then back to IDLE on the argument word.
//  - Discharge instead walks DIS1 -> DIS2 -> DIS3 -> IDLE.
//  - A word with nonzero upper bits (bus[BUS_W-1:3]) aborts to IDLE, no action.
//  - While a start sequence runs, opcodes other than 6 are ignored (FSM stays IDLE).
//  - Opcode 6 always cancels the start sequence and zeroes the timer on acceptance.
//  - Argument word must be 0, otherwise the frame is dropped. Actions take effect the cycle after the argument edge.
//  - Frames: 0/0 OFF. 1/0 PLUS. 2/0 MINUS. 3/0 BAL_P. 4/0 BAL_N.
//  - 5/0 START: pattern OFF, o_fan=1, o_st=0, o_ch=1, timer=FREQ*START_WAIT_S.
//  - 6/0 SHUTDOWN: pattern OFF, o_st=o_ch=o_fan=0.
//  - 7,0,7,1 DISCHARGE: PLUS pattern, applied only when o_st=0 && o_ch=0.
//  - PLUS/MINUS/BAL_* apply only when o_st=1 && o_ch=0; otherwise ignored.
//  Start sequence
//  - WAIT_ST: when the timer reaches 0, o_st=1 and timer=FREQ*CH_HOLD_S.
//  - WAIT_CH: when the timer reaches 0, o_ch=0, then back to idle.
//  - Timer width = $clog2(FREQ*START_WAIT_S+1); it decrements by 1 per clk while nonzero.
//  Pattern map (top/bot one-hot, leg number)
//  - PLUS: TOP1/BOT2, o_plus.
//  - MINUS: TOP2/BOT1, o_minus.
//  - BAL_P: TOP3/BOT4, o_pause_p.
//  - BAL_N: TOP4/BOT3, o_pause_n.
//  - OFF: all 0.
//  Dead time
//  - Change A->B with A,B both nonzero and A!=B: legs and flags go to 0 for exactly DEADTIME_CYC cycles, then B.
//  - Any ->OFF and OFF->any apply immediately. Same pattern re-requested: no gap.
//  - A new request during a gap replaces the pending pattern without restarting the gap counter.
//  - OFF during a gap cancels the pending pattern.
//  - o_top & o_bot on the same leg index is never 1.
//  Error latch
//  - Any err bit or stop_k high sets ERROR (same cycle as a colliding frame action; error wins).
//  - ERROR forces pattern OFF with no gap, o_st=o_ch=0, o_fan=1, o_break=1.
//  - ERROR also aborts the start sequence; the decoder sits in ERROR and idle=0.
//  - stop_k additionally sets o_stop. Strobes are ignored in ERROR.
//  - err_clr while all err=0 and stop_k=0: ERROR exits to IDLE and o_break=o_stop=0; o_fan holds.
//  - err_clr while any fault is still high is ignored.
// STRUCTURE
//  - Package bridge_pkg: opcode localparams (OP_PAUSE..OP_DISCHARGE), rx_state_t, start_state_t, bridge_pat_t.
//  - bridge_pkg also holds function pat_to_legs(bridge_pat_t) returning {top,bot,flags}.
//  - One sub-module bridge_deadtime: takes the requested pattern and a load pulse, outputs the applied pattern; holds the gap counter.
//  - Top body: single registered state struct with next-state always_comb.
// TESTING (FREQ=100, START_WAIT_S=2, CH_HOLD_S=1, DEADTIME_CYC=4)
//  1 rstn=0 with strb low, release, raise and drop strb with bus=0 -> exactly one word taken; all outputs 0, idle=1 before.
//  2 Frame 5/0 -> o_ch=1, o_fan=1; o_st rises 200 cycles later; o_ch falls 100 cycles after that; 1/0 sent mid-wait ignored.
//  3 After start, 1/0 then 2/0 -> TOP1/BOT2, then 4 cycles all-zero, then TOP2/BOT1; 3/0 sent during the gap -> TOP3/BOT4 at gap end.
//  4 err[2]=1 while PLUS applied -> next cycle legs 0, o_break=1, idle=0; err_clr with err[2]=1 ignored; after err=0, err_clr -> idle=1.
//  5 o_st=0,o_ch=0: 7,0,7,1 -> TOP1/BOT2; 7,0,7,0 -> no change; bus=4'b1000 (BUS_W=4) mid-frame -> aborts to IDLE.
//  6 6/0 during WAIT_ST -> o_ch=o_fan=0, timer=0, o_st stays 0.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types for the bridge command controller: opcodes, FSM states,
// bridge patterns and the pattern-to-gate decode.
package bridge_pkg;

  localparam logic [2:0] OP_PAUSE     = 3'd0;
  localparam logic [2:0] OP_PLUS      = 3'd1;
  localparam logic [2:0] OP_MINUS     = 3'd2;
  localparam logic [2:0] OP_BAL_P     = 3'd3;
  localparam logic [2:0] OP_BAL_N     = 3'd4;
  localparam logic [2:0] OP_START     = 3'd5;
  localparam logic [2:0] OP_SHUTDOWN  = 3'd6;
  localparam logic [2:0] OP_DISCHARGE = 3'd7;

  typedef enum logic [2:0] {
    RX_IDLE, RX_ARG, RX_DIS1, RX_DIS2, RX_DIS3, RX_ERR
  } rx_state_t;

  typedef enum logic [1:0] {
    SS_IDLE, SS_WAIT_ST, SS_WAIT_CH
  } start_state_t;

  typedef enum logic [2:0] {
    PAT_OFF, PAT_PLUS, PAT_MINUS, PAT_BAL_P, PAT_BAL_N
  } bridge_pat_t;

  // flags[0..3] = plus, minus, pause_p, pause_n
  typedef struct packed {
    logic [3:0] top;
    logic [3:0] bot;
    logic [3:0] flags;
  } legs_t;

  function automatic legs_t pat_to_legs(input bridge_pat_t p);
    legs_t l;
    l = '0;
    case (p)
      PAT_PLUS:  begin l.top = 4'b0001; l.bot = 4'b0010; l.flags = 4'b0001; end
      PAT_MINUS: begin l.top = 4'b0010; l.bot = 4'b0001; l.flags = 4'b0010; end
      PAT_BAL_P: begin l.top = 4'b0100; l.bot = 4'b1000; l.flags = 4'b0100; end
      PAT_BAL_N: begin l.top = 4'b1000; l.bot = 4'b0100; l.flags = 4'b1000; end
      default:   l = '0;
    endcase
    return l;
  endfunction

  function automatic bridge_pat_t op_to_pat(input logic [2:0] op);
    bridge_pat_t p;
    case (op)
      OP_PLUS:  p = PAT_PLUS;
      OP_MINUS: p = PAT_MINUS;
      OP_BAL_P: p = PAT_BAL_P;
      OP_BAL_N: p = PAT_BAL_N;
      default:  p = PAT_OFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/bridge_deadtime.sv
// Applies requested bridge patterns, inserting an all-off gap between two
// different non-zero patterns; gate outputs are registered.
module bridge_deadtime
  import bridge_pkg::*;
#(
  parameter int DEADTIME_CYC = 50
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_load,
  input  logic        i_kill,
  input  logic [2:0]  i_req,
  output logic [11:0] o_legs
);

  localparam int CW = $clog2(DEADTIME_CYC + 1);
  localparam logic [CW-1:0] GAP = CW'(DEADTIME_CYC);

  bridge_pat_t   r_pat, r_pend, w_pat_n, w_pend_n, w_req;
  logic [CW-1:0] r_cnt, w_cnt_n;
  legs_t         r_legs;

  assign w_req  = bridge_pat_t'(i_req);
  assign o_legs = r_legs;

  always_comb begin
    w_pat_n  = r_pat;
    w_pend_n = r_pend;
    w_cnt_n  = r_cnt;
    if (i_kill) begin
      w_pat_n  = PAT_OFF;
      w_pend_n = PAT_OFF;
      w_cnt_n  = '0;
    end else if (r_cnt != '0) begin
      // gap running: applied is OFF; a new request only swaps the pending pattern
      if (i_load) w_pend_n = w_req;
      if (i_load && w_req == PAT_OFF) begin
        w_pend_n = PAT_OFF;
        w_cnt_n  = '0;
      end else if (r_cnt == CW'(1)) begin
        w_pat_n  = w_pend_n;
        w_pend_n = PAT_OFF;
        w_cnt_n  = '0;
      end else begin
        w_cnt_n = r_cnt - CW'(1);
      end
    end else if (i_load) begin
      if (w_req == PAT_OFF || r_pat == PAT_OFF || w_req == r_pat) begin
        w_pat_n = w_req;
      end else begin
        w_pat_n  = PAT_OFF;
        w_pend_n = w_req;
        w_cnt_n  = GAP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pat  <= PAT_OFF;
      r_pend <= PAT_OFF;
      r_cnt  <= '0;
      r_legs <= '0;
    end else begin
      r_pat  <= w_pat_n;
      r_pend <= w_pend_n;
      r_cnt  <= w_cnt_n;
      r_legs <= pat_to_legs(w_pat_n);
    end
  end

endmodule

// File: rtl/bridge_cmd_ctrl.sv
// Bridge command controller: strobed frame decoder, charge/start timing,
// error latch, and the dead-time pattern stage driving the H-bridge legs.
module bridge_cmd_ctrl
  import bridge_pkg::*;
#(
  parameter int FREQ         = 50000000,
  parameter int BUS_W        = 3,
  parameter int START_WAIT_S = 15,
  parameter int CH_HOLD_S    = 1,
  parameter int DEADTIME_CYC = 50,
  parameter int N_ERR        = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             strb,
  input  logic [BUS_W-1:0] bus,
  input  logic [N_ERR-1:0] err,
  input  logic             stop_k,
  input  logic             err_clr,
  output logic [3:0]       o_top,
  output logic [3:0]       o_bot,
  output logic             o_plus,
  output logic             o_minus,
  output logic             o_pause_p,
  output logic             o_pause_n,
  output logic             o_st,
  output logic             o_ch,
  output logic             o_fan,
  output logic             o_break,
  output logic             o_stop,
  output logic             idle,
  output logic             err_active
);

  localparam longint unsigned ST_CYC = longint'(FREQ) * longint'(START_WAIT_S);
  localparam longint unsigned CH_CYC = longint'(FREQ) * longint'(CH_HOLD_S);
  localparam int TW = $clog2(ST_CYC + 1);
  localparam logic [TW-1:0] ST_LOAD = ST_CYC[TW-1:0];
  localparam logic [TW-1:0] CH_LOAD = CH_CYC[TW-1:0];

  typedef struct packed {
    rx_state_t    rx;
    start_state_t ss;
    logic [2:0]   op;
    logic [TW-1:0] timer;
    logic         st;
    logic         ch;
    logic         fan;
    logic         brk;
    logic         stop;
    logic         strb_q;
  } ctl_t;

  ctl_t        r, n;
  logic        w_fall, w_hi, w_fault, w_load, w_kill;
  logic [2:0]  w_op;
  bridge_pat_t w_req;
  logic [11:0] w_legs;

  assign w_op    = bus[2:0];
  assign w_fall  = r.strb_q & ~strb;
  assign w_fault = (|err) | stop_k;

  generate
    if (BUS_W > 3) begin : g_hi
      assign w_hi = |bus[BUS_W-1:3];
    end else begin : g_nohi
      assign w_hi = 1'b0;
    end
  endgenerate

  always_comb begin
    n        = r;
    w_load   = 1'b0;
    w_kill   = 1'b0;
    w_req    = PAT_OFF;
    n.strb_q = strb;

    // outputs change on the same edge the timer reaches zero
    case (r.ss)
      SS_WAIT_ST: begin
        if (r.timer <= TW'(1)) begin
          n.st    = 1'b1;
          n.timer = CH_LOAD;
          n.ss    = SS_WAIT_CH;
        end else begin
          n.timer = r.timer - TW'(1);
        end
      end
      SS_WAIT_CH: begin
        if (r.timer <= TW'(1)) begin
          n.ch    = 1'b0;
          n.timer = '0;
          n.ss    = SS_IDLE;
        end else begin
          n.timer = r.timer - TW'(1);
        end
      end
      default: n.timer = (r.timer != '0) ? r.timer - TW'(1) : '0;
    endcase

    if (w_fall && r.rx != RX_ERR) begin
      if (w_hi) begin
        n.rx = RX_IDLE;
      end else begin
        case (r.rx)
          RX_IDLE: begin
            if (w_op == OP_SHUTDOWN) begin
              n.rx    = RX_ARG;
              n.op    = w_op;
              n.ss    = SS_IDLE;
              n.timer = '0;
              n.st    = r.st;
              n.ch    = r.ch;
            end else if (r.ss == SS_IDLE) begin
              n.op = w_op;
              n.rx = (w_op == OP_DISCHARGE) ? RX_DIS1 : RX_ARG;
            end
          end
          RX_ARG: begin
            n.rx = RX_IDLE;
            if (w_op == 3'd0) begin
              case (r.op)
                OP_PAUSE: w_load = 1'b1;
                OP_PLUS, OP_MINUS, OP_BAL_P, OP_BAL_N: begin
                  if (r.st && !r.ch) begin
                    w_load = 1'b1;
                    w_req  = op_to_pat(r.op);
                  end
                end
                OP_START: begin
                  w_load  = 1'b1;
                  n.fan   = 1'b1;
                  n.st    = 1'b0;
                  n.ch    = 1'b1;
                  n.timer = ST_LOAD;
                  n.ss    = SS_WAIT_ST;
                end
                OP_SHUTDOWN: begin
                  w_load  = 1'b1;
                  n.fan   = 1'b0;
                  n.st    = 1'b0;
                  n.ch    = 1'b0;
                  n.timer = '0;
                  n.ss    = SS_IDLE;
                end
                default: ;
              endcase
            end
          end
          RX_DIS1: n.rx = (w_op == 3'd0) ? RX_DIS2 : RX_IDLE;
          RX_DIS2: n.rx = (w_op == OP_DISCHARGE) ? RX_DIS3 : RX_IDLE;
          RX_DIS3: begin
            n.rx = RX_IDLE;
            if (w_op == 3'd1 && !r.st && !r.ch) begin
              w_load = 1'b1;
              w_req  = PAT_PLUS;
            end
          end
          default: n.rx = RX_IDLE;
        endcase
      end
    end

    // a fault overrides whatever the decoder did this cycle
    if (w_fault) begin
      n.rx    = RX_ERR;
      n.ss    = SS_IDLE;
      n.timer = '0;
      n.st    = 1'b0;
      n.ch    = 1'b0;
      n.fan   = 1'b1;
      n.brk   = 1'b1;
      if (stop_k) n.stop = 1'b1;
      w_kill  = 1'b1;
      w_load  = 1'b0;
    end else if (r.rx == RX_ERR && err_clr) begin
      n.rx   = RX_IDLE;
      n.brk  = 1'b0;
      n.stop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) r <= '0;
    else       r <= n;
  end

  bridge_deadtime #(.DEADTIME_CYC(DEADTIME_CYC)) u_dt (
    .clk    (clk),
    .rstn   (rstn),
    .i_load (w_load),
    .i_kill (w_kill),
    .i_req  (w_req),
    .o_legs (w_legs)
  );

  assign o_top      = w_legs[11:8];
  assign o_bot      = w_legs[7:4];
  assign o_plus     = w_legs[0];
  assign o_minus    = w_legs[1];
  assign o_pause_p  = w_legs[2];
  assign o_pause_n  = w_legs[3];
  assign o_st       = r.st;
  assign o_ch       = r.ch;
  assign o_fan      = r.fan;
  assign o_break    = r.brk;
  assign o_stop     = r.stop;
  assign idle       = (r.rx == RX_IDLE);
  assign err_active = (r.rx == RX_ERR);

endmodule

// File: tb/tb_bridge_cmd_ctrl.sv
// Directed + randomized bench for bridge_cmd_ctrl with a small in-bench
// expectation model of pattern application and timing.
module tb_bridge_cmd_ctrl;

  localparam int FREQ = 100, START_WAIT_S = 2, CH_HOLD_S = 1, DEADTIME_CYC = 4;
  localparam int BUS_W = 4, N_ERR = 8;

  logic clk = 1'b0, rstn = 1'b0, strb = 1'b0, stop_k = 1'b0, err_clr = 1'b0;
  logic [BUS_W-1:0] bus = '0;
  logic [N_ERR-1:0] err = '0;
  logic [3:0] o_top, o_bot;
  logic o_plus, o_minus, o_pause_p, o_pause_n;
  logic o_st, o_ch, o_fan, o_break, o_stop, idle, err_active;

  int checks = 0, failures = 0, cyc = 0;
  int t0, t1, t2, cur, p, imm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bridge_cmd_ctrl #(
    .FREQ(FREQ), .BUS_W(BUS_W), .START_WAIT_S(START_WAIT_S), .CH_HOLD_S(CH_HOLD_S),
    .DEADTIME_CYC(DEADTIME_CYC), .N_ERR(N_ERR)
  ) dut (
    .clk(clk), .rstn(rstn), .strb(strb), .bus(bus), .err(err), .stop_k(stop_k),
    .err_clr(err_clr), .o_top(o_top), .o_bot(o_bot), .o_plus(o_plus), .o_minus(o_minus),
    .o_pause_p(o_pause_p), .o_pause_n(o_pause_n), .o_st(o_st), .o_ch(o_ch), .o_fan(o_fan),
    .o_break(o_break), .o_stop(o_stop), .idle(idle), .err_active(err_active)
  );

  wire [11:0] legs = {o_top, o_bot, o_pause_n, o_pause_p, o_minus, o_plus};
  wire [4:0]  lat  = {o_st, o_ch, o_fan, o_break, o_stop};

  // 0 OFF, 1 PLUS, 2 MINUS, 3 BAL_P, 4 BAL_N
  function automatic logic [11:0] exp_legs(input int pat);
    case (pat)
      1:       return {4'b0001, 4'b0010, 4'b0001};
      2:       return {4'b0010, 4'b0001, 4'b0010};
      3:       return {4'b0100, 4'b1000, 4'b0100};
      4:       return {4'b1000, 4'b0100, 4'b1000};
      default: return 12'h000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_legs(input string tag, input int pat);
    chk(tag, {20'h0, legs}, {20'h0, exp_legs(pat)});
    chk({tag, "_overlap"}, {28'h0, o_top & o_bot}, 32'h0);
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_word(input logic [3:0] w);
    bus = w; strb = 1'b1; tick(1);
    strb = 1'b0; tick(1);
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b);
    send_word(a);
    send_word(b);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(1);
    err_clr = 1'b0; tick(1);
  endtask

  initial begin
    // 1: reset with strobe held low, then exactly one word taken
    tick(2);
    chk("rst_latches", {27'h0, lat}, 32'h0);
    chk_legs("rst_legs", 0);
    chk("rst_idle", {31'h0, idle}, 32'h1);
    chk("rst_err_active", {31'h0, err_active}, 32'h0);
    rstn = 1'b1; tick(2);
    chk("post_rst_no_edge", {31'h0, idle}, 32'h1);
    send_word(4'd0);
    chk("one_word_taken", {31'h0, idle}, 32'h0);
    send_word(4'd0);
    chk("off_frame_idle", {31'h0, idle}, 32'h1);

    // 2: start sequence timing; PLUS mid-wait is ignored
    send_frame(4'd5, 4'd0);
    chk("start_latches", {27'h0, lat}, 32'b01100);
    t0 = cyc;
    tick(50);
    send_frame(4'd1, 4'd0);
    chk_legs("plus_ignored_in_wait", 0);
    chk("idle_in_wait", {31'h0, idle}, 32'h1);
    for (int i = 0; i < 400 && !o_st; i++) tick(1);
    t1 = cyc;
    chk("st_delay", t1 - t0, 200);
    chk("st_latches", {27'h0, lat}, 32'b11100);
    for (int i = 0; i < 300 && o_ch; i++) tick(1);
    t2 = cyc;
    chk("ch_hold", t2 - t1, 100);
    chk("run_latches", {27'h0, lat}, 32'b10100);

    // 3: dead time between non-zero patterns
    send_frame(4'd1, 4'd0);
    chk_legs("plus_applied", 1);
    send_frame(4'd2, 4'd0);
    for (int i = 0; i < DEADTIME_CYC; i++) begin
      chk_legs("gap_zero", 0);
      tick(1);
    end
    chk_legs("minus_after_gap", 2);
    send_frame(4'd1, 4'd0);
    chk_legs("gap2_c0", 0);
    bus = 4'd3; strb = 1'b1; tick(1);
    chk_legs("gap2_c1", 0);
    strb = 1'b0; tick(1);
    chk_legs("gap2_c2", 0);
    bus = 4'd0; strb = 1'b1; tick(1);
    chk_legs("gap2_c3", 0);
    strb = 1'b0; tick(1);
    chk_legs("balp_at_gap_end", 3);
    tick(3);
    chk_legs("balp_holds", 3);

    // randomized pattern requests against the dead-time rules
    cur = 3;
    for (int k = 0; k < 24; k++) begin
      p = int'($urandom_range(0, 4));
      send_frame(4'(p), 4'd0);
      imm = (p == 0 || cur == 0 || p == cur) ? p : 0;
      chk_legs("rnd_immediate", imm);
      tick(DEADTIME_CYC);
      chk_legs("rnd_settled", p);
      cur = p;
      tick(int'($urandom_range(0, 3)));
    end

    // 4: error latch
    send_frame(4'd1, 4'd0);
    tick(DEADTIME_CYC + 1);
    chk_legs("pre_err_plus", 1);
    err[2] = 1'b1; tick(1);
    chk_legs("err_legs_off", 0);
    chk("err_latches", {27'h0, lat}, 32'b00110);
    chk("err_idle", {31'h0, idle}, 32'h0);
    chk("err_active_set", {31'h0, err_active}, 32'h1);
    pulse_clr();
    chk("clr_ignored", {31'h0, err_active}, 32'h1);
    send_frame(4'd1, 4'd0);
    chk_legs("strobe_ignored_in_err", 0);
    err = '0; tick(2);
    chk("err_still_latched", {27'h0, lat}, 32'b00110);
    pulse_clr();
    chk("clr_idle", {31'h0, idle}, 32'h1);
    chk("clr_latches", {27'h0, lat}, 32'b00100);
    stop_k = 1'b1; tick(1);
    chk("stop_latches", {27'h0, lat}, 32'b00111);
    stop_k = 1'b0; tick(1);
    pulse_clr();
    chk("stop_clr_latches", {27'h0, lat}, 32'b00100);

    // 5: discharge frames and upper-bit abort
    send_frame(4'd7, 4'd0); send_frame(4'd7, 4'd1);
    chk_legs("discharge_plus", 1);
    send_frame(4'd0, 4'd0);
    chk_legs("off_after_discharge", 0);
    send_frame(4'd7, 4'd0); send_frame(4'd7, 4'd0);
    chk_legs("bad_discharge_nochange", 0);
    chk("bad_discharge_idle", {31'h0, idle}, 32'h1);
    send_word(4'd7);
    chk("dis_midframe", {31'h0, idle}, 32'h0);
    send_word(4'b1000);
    chk("upper_bits_abort", {31'h0, idle}, 32'h1);
    send_word(4'd0); send_word(4'd7); send_word(4'd1);
    chk_legs("no_discharge_after_abort", 0);
    chk("opcode_after_abort", {31'h0, idle}, 32'h0);
    send_word(4'd0);
    chk("abort_seq_idle", {31'h0, idle}, 32'h1);

    // 6: shutdown during WAIT_ST
    send_frame(4'd5, 4'd0);
    chk("start2_latches", {27'h0, lat}, 32'b01100);
    tick(50);
    send_frame(4'd6, 4'd0);
    chk("shutdown_latches", {27'h0, lat}, 32'b00000);
    tick(250);
    chk("shutdown_no_st", {27'h0, lat}, 32'b00000);

    // reset mid-start aborts the sequence
    send_frame(4'd5, 4'd0);
    tick(10);
    rstn = 1'b0; tick(1);
    chk("midrst_latches", {27'h0, lat}, 32'h0);
    chk("midrst_idle", {31'h0, idle}, 32'h1);
    rstn = 1'b1; tick(300);
    chk("midrst_no_st", {27'h0, lat}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
